// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_wrapper TX write port among NUM_REQ byte sources.
// Optional macro UART_ARB_PRIORITY_EN: requester 0 wins every arbitration it takes part in.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int MAX_BURST     = 16,
    parameter int STALL_TIMEOUT = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_full,
    output logic                           wr_uart,
    output logic [DATA_BITS-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_q, last_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic [SW-1:0]        stall_q, stall_d;
    logic [DATA_BITS-1:0] wr_data_q;

    logic [DATA_BITS-1:0] data_arr [NUM_REQ];
    logic [GW-1:0]        pick;
    logic                 owner_valid, owner_last, ready_ok, transfer;
    logic [DATA_BITS-1:0] owner_data;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    // Search starts just after the previous owner, wrapping modulo NUM_REQ.
    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_q) + i) % NUM_REQ;
            if (!found && req_valid[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
`ifdef UART_ARB_PRIORITY_EN
        if (req_valid[0]) begin
            pick = '0;
        end
`endif
    end

    assign owner_valid = req_valid[grant_q];
    assign owner_last  = req_last[grant_q];
    assign owner_data  = data_arr[grant_q];
    // Reset gates the handshake so no byte slips out during the reset cycle.
    assign ready_ok    = (state_q == BURST) && !tx_full && !reset;
    assign transfer    = ready_ok && owner_valid;

    always_comb begin
        req_ready = '0;
        if (ready_ok) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    assign wr_uart  = transfer;
    assign wr_data  = transfer ? owner_data : wr_data_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == BURST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        stall_d = stall_q;
        case (state_q)
            IDLE: begin
                burst_d = '0;
                stall_d = '0;
                if (|req_valid) begin
                    grant_d = pick;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (transfer) begin
                    stall_d = '0;
                    if (owner_last || burst_q == BW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end else if (!owner_valid) begin
                    if (stall_q == SW'(STALL_TIMEOUT - 1)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                        burst_d = '0;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_REQ - 1);
            burst_q   <= '0;
            stall_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            stall_q <= stall_d;
            if (transfer) begin
                wr_data_q <= owner_data;
            end
        end
    end

endmodule
